// File: rtl/axil_reg_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
//   RESP_*  : AXI response codes
//   OFF_*   : word offsets (addr[3:2]) inside the 16-byte window
//   wr_state_t / rd_state_t : write and read channel FSM states
//   strb_mask : expands a 4-bit byte strobe to a 32-bit bit mask
package axil_reg_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_ACC    = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/axil_reg_core.sv
// Register file behind the AXI-Lite slave: CTRL, DATA, STATUS counters, ACC.
//   wr_en/wr_off/wr_data/wr_strb/wr_ok : write commit (one cycle pulse);
//                                        state changes only when wr_ok
//   rd_en/rd_off/rd_ok                 : read handshake, bumps rd_cnt when rd_ok
//   rd_data                            : combinational read mux of current state
module axil_reg_core
  import axil_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_ok,
  input  logic        rd_en,
  input  logic [1:0]  rd_off,
  input  logic        rd_ok,
  output logic [31:0] rd_data
);

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] mask;

  always_comb begin
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    acc_d    = acc_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mask     = strb_mask(wr_strb);
    if (wr_en && wr_ok) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
      case (wr_off)
        OFF_CTRL: begin
          // ACC_CLR is a pulse: never stored, always reads back 0
          ctrl_d = ((ctrl_q & ~mask) | (wr_data & mask)) & ~32'h2;
          if (wr_data[1] && wr_strb[0]) acc_d = '0;
        end
        OFF_DATA: begin
          data_d = (data_q & ~mask) | (wr_data & mask);
          if (ctrl_q[0]) acc_d = acc_q + data_d;
        end
        default: ;
      endcase
    end
    if (rd_en && rd_ok) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      acc_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Reads see pre-update state, so STATUS returns its pre-increment value and
  // a read racing a write commit returns the old contents.
  always_comb begin
    case (rd_off)
      OFF_CTRL:   rd_data = ctrl_q;
      OFF_DATA:   rd_data = data_q;
      OFF_STATUS: rd_data = {wr_cnt_q, rd_cnt_q};
      default:    rd_data = acc_q;
    endcase
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing a 4-word register window at BASE_ADDR.
//   s_axi_aclk/s_axi_aresetn : clock, async active-low reset
//   AW/W/B                   : write channel, one outstanding write
//   AR/R                     : read channel, one outstanding read
// Write and read channels run independent FSMs; registers live in axil_reg_core.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;

  logic                  awready_q, wready_q, bvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q;
  logic                  aw_got_q, w_got_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] rresp_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_hit, wr_ok, rd_hit;
  logic [31:0]           core_rdata;
  logic                  unused;

  assign aw_hs = awready_q && s_axi_awvalid;
  assign w_hs  = wready_q  && s_axi_wvalid;
  assign ar_hs = arready_q && s_axi_arvalid;

  // The beat arriving this cycle bypasses its holding register so the commit
  // happens on the same edge as the second handshake.
  always_comb begin
    wr_addr   = aw_got_q ? awaddr_q : s_axi_awaddr;
    wr_data   = w_got_q  ? wdata_q  : s_axi_wdata[31:0];
    wr_strb   = w_got_q  ? wstrb_q  : s_axi_wstrb[3:0];
    wr_commit = (wr_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    wr_hit    = wr_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    wr_ok     = wr_hit && !wr_addr[3];
    rd_hit    = s_axi_araddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  end

  assign unused = ^{s_axi_wstrb[DATA_WIDTH/8], wr_addr[1:0], s_axi_araddr[1:0]};

  axil_reg_core u_core (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .wr_en   (wr_commit),
    .wr_off  (wr_addr[3:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_ok   (wr_ok),
    .rd_en   (ar_hs),
    .rd_off  (s_axi_araddr[3:2]),
    .rd_ok   (rd_hit),
    .rd_data (core_rdata)
  );

  // Write FSM. Readies reset low and rise on the first edge after release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (wr_commit) begin
            wr_state_q <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_got_q  <= 1'b1;
              awaddr_q  <= s_axi_awaddr;
              awready_q <= 1'b0;
            end else if (!aw_got_q) begin
              awready_q <= 1'b1;
            end
            if (w_hs) begin
              w_got_q  <= 1'b1;
              wdata_q  <= s_axi_wdata[31:0];
              wstrb_q  <= s_axi_wstrb[3:0];
              wready_q <= 1'b0;
            end else if (!w_got_q) begin
              wready_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= R_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_hit ? DATA_WIDTH'(core_rdata) : '0;
            rresp_q    <= rd_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: two instances (BASE 0x00 and 0x10) on a shared
// stimulus bus, selected by sel. Expected values come from a register-level
// model of the window (arrays per instance).
module tb_axil_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;

  logic [1:0]  awready_v, wready_v, bvalid_v, arready_v, rvalid_v;
  logic [2:0]  bresp_v [2];
  logic [2:0]  rresp_v [2];
  logic [31:0] rdata_v [2];

  logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [2:0]  bresp_m, rresp_m;
  logic [31:0] rdata_m;

  assign awready_m = awready_v[sel];
  assign wready_m  = wready_v[sel];
  assign bvalid_m  = bvalid_v[sel];
  assign arready_m = arready_v[sel];
  assign rvalid_m  = rvalid_v[sel];
  assign bresp_m   = bresp_v[sel];
  assign rresp_m   = rresp_v[sel];
  assign rdata_m   = rdata_v[sel];

  always #5 clk = ~clk;

  axil_reg_slave #(.BASE_ADDR(8'h00)) u_dut0 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && !sel), .s_axi_awready(awready_v[0]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && !sel), .s_axi_wready(wready_v[0]),
    .s_axi_bresp(bresp_v[0]), .s_axi_bvalid(bvalid_v[0]), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && !sel), .s_axi_arready(arready_v[0]),
    .s_axi_rdata(rdata_v[0]), .s_axi_rresp(rresp_v[0]), .s_axi_rvalid(rvalid_v[0]), .s_axi_rready(rready)
  );

  axil_reg_slave #(.BASE_ADDR(8'h10)) u_dut1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && sel), .s_axi_awready(awready_v[1]),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && sel), .s_axi_wready(wready_v[1]),
    .s_axi_bresp(bresp_v[1]), .s_axi_bvalid(bvalid_v[1]), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && sel), .s_axi_arready(arready_v[1]),
    .s_axi_rdata(rdata_v[1]), .s_axi_rresp(rresp_v[1]), .s_axi_rvalid(rvalid_v[1]), .s_axi_rready(rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ctrl [2];
  logic [31:0] m_data [2];
  logic [31:0] m_acc  [2];
  logic [15:0] m_wc   [2];
  logic [15:0] m_rc   [2];

  function automatic void mdl_clear();
    for (int i = 0; i < 2; i++) begin
      m_ctrl[i] = '0; m_data[i] = '0; m_acc[i] = '0; m_wc[i] = '0; m_rc[i] = '0;
    end
  endfunction

  function automatic logic mdl_hit(input int i, input logic [7:0] a);
    return a[7:4] == 4'(i);
  endfunction

  function automatic void mdl_write(input int i, input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
    logic [31:0] m, nv;
    if (!mdl_hit(i, a) || a[3]) return;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    m_wc[i] = m_wc[i] + 16'd1;
    if (!a[2]) begin
      nv = (m_ctrl[i] & ~m) | (d & m);
      nv[1] = 1'b0;
      if (d[1] && s[0]) m_acc[i] = '0;
      m_ctrl[i] = nv;
    end else begin
      m_data[i] = (m_data[i] & ~m) | (d & m);
      if (m_ctrl[i][0]) m_acc[i] = m_acc[i] + m_data[i];
    end
  endfunction

  function automatic void mdl_read(input int i, input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
    if (!mdl_hit(i, a)) begin
      d = '0; r = 3'd2; return;
    end
    r = 3'd0;
    case (a[3:2])
      2'd0: d = m_ctrl[i];
      2'd1: d = m_data[i];
      2'd2: d = {m_wc[i], m_rc[i]};
      default: d = m_acc[i];
    endcase
    m_rc[i] = m_rc[i] + 16'd1;
  endfunction

  // ---------------- bus tasks (enter and leave at a negedge) ----------------
  task automatic axi_write(input int inst, input logic [7:0] a, input logic [31:0] d,
                           input logic [4:0] s, input int aw_dly, input int w_dly, input int b_dly);
    bit aw_ok, w_ok, w_done;
    logic [2:0] er;
    aw_ok = 0; w_ok = 0; w_done = 0;
    er = (mdl_hit(inst, a) && !a[3]) ? 3'd0 : 3'd2;
    sel = inst[0];
    fork
      begin
        repeat (aw_dly) begin
          @(negedge clk);
          if (w_done) chk("wready_low", {31'b0, wready_m}, 32'd0);
        end
        awaddr = a; awvalid = 1'b1;
        for (int n = 0; n < 40; n++) begin
          if (awready_m) begin aw_ok = 1; break; end
          @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int n = 0; n < 40; n++) begin
          if (wready_m) begin w_ok = 1; break; end
          @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        wvalid = 1'b0; w_done = 1;
      end
    join
    chk("aw_handshake", {31'b0, aw_ok}, 32'd1);
    chk("w_handshake", {31'b0, w_ok}, 32'd1);
    chk("bvalid_lat", {31'b0, bvalid_m}, 32'd1);
    chk("bresp", {29'b0, bresp_m}, {29'b0, er});
    repeat (b_dly) begin
      @(negedge clk);
      chk("bvalid_hold", {31'b0, bvalid_m}, 32'd1);
      chk("bresp_hold", {29'b0, bresp_m}, {29'b0, er});
      chk("wready_resp", {31'b0, wready_m}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", {31'b0, bvalid_m}, 32'd0);
    mdl_write(inst, a, d, s);
  endtask

  task automatic axi_read(input int inst, input logic [7:0] a, input int r_dly, output logic [31:0] got);
    logic [31:0] ed;
    logic [2:0]  er;
    bit ok;
    ok = 0;
    mdl_read(inst, a, ed, er);
    sel = inst[0];
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (arready_m) begin ok = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    chk("ar_handshake", {31'b0, ok}, 32'd1);
    chk("rvalid_lat", {31'b0, rvalid_m}, 32'd1);
    chk("rdata", rdata_m, ed);
    chk("rresp", {29'b0, rresp_m}, {29'b0, er});
    got = rdata_m;
    repeat (r_dly) begin
      @(negedge clk);
      chk("rvalid_hold", {31'b0, rvalid_m}, 32'd1);
      chk("rdata_hold", rdata_m, ed);
      chk("arready_busy", {31'b0, arready_m}, 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    chk("rvalid_drop", {31'b0, rvalid_m}, 32'd0);
  endtask

  task automatic chk_reset_outs();
    for (int i = 0; i < 2; i++) begin
      chk("rst_awready", {31'b0, awready_v[i]}, 32'd0);
      chk("rst_wready", {31'b0, wready_v[i]}, 32'd0);
      chk("rst_arready", {31'b0, arready_v[i]}, 32'd0);
      chk("rst_bvalid", {31'b0, bvalid_v[i]}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid_v[i]}, 32'd0);
      chk("rst_bresp", {29'b0, bresp_v[i]}, 32'd0);
      chk("rst_rresp", {29'b0, rresp_v[i]}, 32'd0);
      chk("rst_rdata", rdata_v[i], 32'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_pre_edge", {30'b0, awready_v | arready_v}, 32'd0);
    @(negedge clk);
    chk("awready_up", {30'b0, awready_v}, 32'd3);
    chk("wready_up", {30'b0, wready_v}, 32'd3);
    chk("arready_up", {30'b0, arready_v}, 32'd3);
  endtask

  logic [31:0] got;
  logic [7:0]  addr_tbl [10];

  initial begin
    addr_tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'hF4};
    mdl_clear();
    #23;
    chk_reset_outs();
    release_reset();

    // aligned write + readback
    axi_write(0, 8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
    axi_read(0, 8'h04, 0, got);
    chk("readback", got, 32'hDEADBEEF);

    // W three cycles before AW, partial strobes
    axi_write(0, 8'h04, 32'h11223344, 5'h03, 3, 0, 0);
    axi_read(0, 8'h04, 0, got);
    chk("strobe_merge", got, 32'hDEAD3344);
    // AW first, top strobe bit set but ignored
    axi_write(0, 8'h05, 32'hAABBCCDD, 5'h1C, 0, 2, 1);

    // accumulator
    axi_write(0, 8'h00, 32'h1, 5'h0F, 0, 0, 0);
    axi_write(0, 8'h04, 32'd5, 5'h0F, 0, 0, 0);
    axi_write(0, 8'h04, 32'd7, 5'h0F, 1, 0, 0);
    axi_read(0, 8'h0C, 0, got);
    chk("acc_sum", got, 32'd12);
    axi_write(0, 8'h00, 32'h3, 5'h0F, 0, 0, 0);
    axi_read(0, 8'h0C, 0, got);
    chk("acc_clr", got, 32'd0);
    axi_read(0, 8'h00, 0, got);
    chk("ctrl_clr_bit", got, 32'd1);
    axi_write(0, 8'h04, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
    axi_write(0, 8'h04, 32'd2, 5'h0F, 0, 0, 0);
    axi_read(0, 8'h0C, 0, got);
    chk("acc_wrap", got, 32'd1);

    // errors
    axi_write(0, 8'h08, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
    axi_read(0, 8'h08, 0, got);
    axi_write(0, 8'h14, 32'h12345678, 5'h0F, 0, 0, 0);
    axi_read(1, 8'h04, 0, got);
    chk("miss_rdata", got, 32'd0);
    axi_read(1, 8'h18, 0, got);

    // backpressure
    axi_write(1, 8'h14, 32'hCAFEF00D, 5'h0F, 0, 0, 5);
    axi_read(1, 8'h14, 5, got);

    // AR on the same edge as a DATA commit returns old DATA
    fork
      axi_write(0, 8'h04, 32'h0BADF00D, 5'h0F, 0, 0, 0);
      begin
        axi_read(0, 8'h04, 0, got);
      end
    join
    chk("race_old_data", got, 32'd1 + 32'hFFFFFFFF - 32'hFFFFFFFF + 32'd1);
    axi_read(0, 8'h04, 0, got);
    chk("race_new_data", got, 32'h0BADF00D);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      int inst;
      logic [7:0] a;
      inst = int'($urandom_range(0, 1));
      a = addr_tbl[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        axi_write(inst, a, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        axi_read(inst, a, int'($urandom_range(0, 2)), got);
    end

    // reset mid R_DATA
    sel = 1'b0; araddr = 8'h04; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    chk("pre_rst_rvalid", {31'b0, rvalid_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid_drop", {31'b0, rvalid_m}, 32'd0);
    chk_reset_outs();
    mdl_clear();
    release_reset();
    for (int i = 0; i < 2; i++) begin
      axi_read(i, 8'(16 * i + 8), 0, got);
      chk("zero_status", got, 32'd0);
      axi_read(i, 8'(16 * i), 0, got);
      chk("zero_ctrl", got, 32'd0);
      axi_read(i, 8'(16 * i + 4), 0, got);
      chk("zero_data", got, 32'd0);
      axi_read(i, 8'(16 * i + 12), 0, got);
      chk("zero_acc", got, 32'd0);
    end

    // counters from a clean reset
    rst_n = 1'b0;
    mdl_clear();
    #3;
    release_reset();
    axi_write(0, 8'h04, 32'h1, 5'h0F, 0, 0, 0);
    axi_write(0, 8'h00, 32'h0, 5'h0F, 2, 0, 0);
    axi_write(0, 8'h04, 32'h2, 5'h0F, 0, 1, 0);
    axi_read(0, 8'h04, 0, got);
    axi_read(0, 8'h00, 0, got);
    axi_read(0, 8'h08, 0, got);
    chk("status_cnt", got, 32'h00030002);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite register slave that terminates one master port of the two-way AXI-Lite bus (m1 or m2 side) and provides a four-word register window. Each instance is placed at a 16-byte base address via BASE_ADDR. Instance 1 sits at 0x00 and instance 2 at 0x10, matching the bus address map: writes to offsets 0x0/0x4, reads from offsets 0x8/0xC. Write and read channels run independent FSMs, and each handles one outstanding transaction.

## Interface
- DATA_WIDTH, 32, data bus width; fixed 32 for this block.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, response width, matching the bus.
- BASE_ADDR, 8'h00, window base; bits [3:0] must be 0.
- s_axi_aclk  in  1  single clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata  in  DATA_WIDTH.
- s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes, width matching the bus; top bit ignored.
- s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bresp  out  RESP_WIDTH; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_WIDTH; s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rdata  out  DATA_WIDTH; s_axi_rresp  out  RESP_WIDTH; s_axi_rvalid  out  1; s_axi_rready  in  1.

## Operation
- **Decode.** An address hits when addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]. The offset is addr[3:2]; addr[1:0] is ignored.
- **Register map.**
  - 0x0 CTRL, RW. Bit 0 is ACC_EN. Bit 1 is ACC_CLR: write-1, self-clearing, always reads 0.
  - 0x4 DATA, RW.
  - 0x8 STATUS, RO: {wr_cnt[15:0], rd_cnt[15:0]}.
  - 0xC ACC, RO.
- **Response codes.** OKAY = 0, SLVERR = 2.
- **Write FSM, W_IDLE → W_RESP → W_IDLE.**
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle. Each ready drops once its beat is captured.
  - On the edge where the second beat is captured: commit the write, set bvalid, and go to W_RESP.
  - A write to 0x0 or 0x4 is byte-masked by wstrb[3:0] and returns OKAY.
  - A write to 0x8, 0xC or a miss returns SLVERR and changes no state.
  - Write to DATA with ACC_EN = 1: ACC <= ACC + new DATA value (merged with strobes), mod 2^32.
  - Write to CTRL with wdata[1] = 1 and wstrb[0] = 1: ACC <= 0 and CTRL[0] takes the new value. A clear takes priority over an accumulate.
  - wr_cnt increments by 1 on each OKAY write and wraps 0xFFFF → 0.
  - In W_RESP, hold bvalid/bresp until bready. Return to W_IDLE with awready = wready = 1.
- **Read FSM, R_IDLE → R_DATA → R_IDLE.**
  - In R_IDLE, arready = 1. On the AR handshake, rdata and rresp are registered and rvalid is set.
  - Any in-window offset returns OKAY. A miss returns SLVERR with rdata = 0.
  - rd_cnt increments on each OKAY read and wraps. A STATUS read returns the value from before its own increment.
  - In R_DATA, arready = 0. Hold rdata/rresp/rvalid until rready, then return to R_IDLE.
- **Simultaneous write commit and AR handshake on the same edge.** The read returns pre-write values.

## Timing
- **Reset** (asynchronous assert, synchronous-safe deassert): all outputs are 0.
  - CTRL, DATA, ACC and both counters are 0.
  - awready, wready and arready rise on the first clock edge after release.
  - Reset mid-transaction drops the transaction: no commit, no response.
- **Write latency.** bvalid is high the cycle after the last of the AW/W handshakes. Minimum write occupancy is 2 cycles with bready held high.
- **Read latency.** rvalid is high the cycle after the AR handshake. Back-to-back reads take 2 cycles each.
- **Hold rule.** No output changes while valid is high and ready is low.

## Structure
- Package axil_reg_pkg holds:
  - response constants RESP_OKAY and RESP_SLVERR;
  - offset constants OFF_CTRL, OFF_DATA, OFF_STATUS and OFF_ACC;
  - typedef enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- One sub-module, axil_reg_core, holds the registers, strobe merge, accumulator and counters. It exposes a write-commit port (offset, data, strobe, ok) and a read-mux port. The top level holds both FSMs.

## Test plan
- **Aligned write and readback, BASE 0x00.** AW = 0x04 and W = 0xDEADBEEF in the same cycle, wstrb = 0xF → bvalid the next cycle, bresp = 0. Then read 0x04 → 0xDEADBEEF, rresp = 0.
- **AW/W ordering and strobes.**
  - W first with wstrb = 0x3, data 0x11223344; AW to 0x04 three cycles later → DATA = 0xDEAD3344.
  - wready stays low after W capture until bvalid&&bready.
- **Accumulator.** CTRL = 1, then write DATA = 5 and DATA = 7 → ACC reads 12. CTRL = 0x3 → ACC reads 0 and CTRL reads 1. Wrap case: ACC 0xFFFFFFFF + 2 → 1.
- **Errors.**
  - Write 0x08 → bresp = 2 and STATUS is unchanged.
  - On BASE 0x10, read 0x04 → rresp = 2, rdata = 0.
  - On BASE 0x10, read 0x18 → rresp = 0.
- **Backpressure and concurrency.**
  - Hold bready/rready low for 5 cycles → bvalid/rvalid and data stay stable.
  - Issue AR to 0x04 on the same edge as a DATA write commit → the old DATA is returned.
- **Counters and reset.**
  - After 3 OKAY writes and 2 OKAY reads, STATUS reads 0x00030002.
  - Assert aresetn low mid-R_DATA → rvalid drops to 0 immediately and all registers read 0 afterwards.
